// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scanner for a common-anode display. Optional
// leading-zero blanking is enabled with the SSD_SCAN_LEADING_ZERO_BLANK_EN macro.
module ssd_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        ssd_scan_clk,
  input  logic        ssd_scan_rst_n,
  input  logic [15:0] ssd_scan_data,
  input  logic [3:0]  ssd_scan_digit_en,
  input  logic [3:0]  ssd_scan_dp,
  output logic [3:0]  ssd_scan_an,
  output logic [6:0]  ssd_scan_seg,
  output logic        ssd_scan_dpo,
  output logic        ssd_scan_frame
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      shadowData_q;
  logic [3:0]       shadowEn_q;
  logic [3:0]       shadowDp_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpo_q, dpo_d;
  logic             frame_q;
  logic             tick;
  logic             load;
  logic [3:0]       curNib;
  logic [3:0]       digitOn;

  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign load  = tick && (sel_q == 2'd3);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign sel_d = tick ? sel_q + 2'd1 : sel_q;

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  logic [3:0] nibZero;
  logic [3:0] zeroOrOff;
  logic [3:0] lzBlank;

  // Blanking is derived from the shadow only, so it cannot change mid-frame.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nibZero[i]   = (shadowData_q[i*4 +: 4] == 4'h0);
      zeroOrOff[i] = nibZero[i] || !shadowEn_q[i];
    end
    lzBlank[3] = nibZero[3];
    lzBlank[2] = nibZero[2] && zeroOrOff[3];
    lzBlank[1] = nibZero[1] && zeroOrOff[3] && zeroOrOff[2];
    lzBlank[0] = 1'b0;
    digitOn    = shadowEn_q & ~lzBlank;
  end
`else
  assign digitOn = shadowEn_q;
`endif

  assign curNib = shadowData_q[{sel_q, 2'b00} +: 4];

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dpo_d = 1'b1;
    if (digitOn[sel_q]) begin
      an_d[sel_q] = 1'b0;
      seg_d       = hexDecode(curNib);
      dpo_d       = ~shadowDp_q[sel_q];
    end
  end

  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
    if (!ssd_scan_rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      shadowData_q <= 16'h0000;
      shadowEn_q   <= 4'h0;
      shadowDp_q   <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dpo_q        <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      frame_q <= load;
      // Shadow reloads on the same edge that sel wraps, so a frame never tears.
      if (load) begin
        shadowData_q <= ssd_scan_data;
        shadowEn_q   <= ssd_scan_digit_en;
        shadowDp_q   <= ssd_scan_dp;
      end
    end
  end

  assign ssd_scan_an    = an_q;
  assign ssd_scan_seg   = seg_q;
  assign ssd_scan_dpo   = dpo_q;
  assign ssd_scan_frame = frame_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed self-checking bench for ssd_scan with a short refresh period (4 cycles/digit).
module tb_ssd_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] dataIn;
  logic [3:0]  enIn;
  logic [3:0]  dpIn;
  logic [3:0]  anO;
  logic [6:0]  segO;
  logic        dpoO;
  logic        frameO;

  int total = 0;
  int bad   = 0;

  logic [6:0] hexSeg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_SWEEP = 4'b1110;
  localparam logic [3:0] LZ_0070  = 4'b1100;
`else
  localparam logic [3:0] LZ_SWEEP = 4'b0000;
  localparam logic [3:0] LZ_0070  = 4'b0000;
`endif

  ssd_scan #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .ssd_scan_clk      (clk),
    .ssd_scan_rst_n    (rst_n),
    .ssd_scan_data     (dataIn),
    .ssd_scan_digit_en (enIn),
    .ssd_scan_dp       (dpIn),
    .ssd_scan_an       (anO),
    .ssd_scan_seg      (segO),
    .ssd_scan_dpo      (dpoO),
    .ssd_scan_frame    (frameO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                             input logic expDpo, input logic expFrame);
    total++;
    assert (anO === expAn) else begin
      bad++;
      $error("[TB] FAIL %s an got=%b exp=%b", tag, anO, expAn);
    end
    total++;
    assert (segO === expSeg) else begin
      bad++;
      $error("[TB] FAIL %s seg got=%h exp=%h", tag, segO, expSeg);
    end
    total++;
    assert (dpoO === expDpo) else begin
      bad++;
      $error("[TB] FAIL %s dpo got=%b exp=%b", tag, dpoO, expDpo);
    end
    total++;
    assert (frameO === expFrame) else begin
      bad++;
      $error("[TB] FAIL %s frame got=%b exp=%b", tag, frameO, expFrame);
    end
  endtask

  // Walks one 16-cycle frame, sampling on the falling edge after each rising edge.
  task automatic checkFrame(input string tag, input logic [15:0] shData, input logic [3:0] shEn,
                            input logic [3:0] shDp, input logic [3:0] lzMask,
                            input int midK, input logic [15:0] midData);
    for (int k = 1; k <= 16; k++) begin
      int         d;
      logic       shown;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic       expDpo;
      d      = (k - 1) / 4;
      shown  = shEn[d] && !lzMask[d];
      expAn  = 4'b1111;
      expSeg = 7'h7F;
      expDpo = 1'b1;
      if (shown) begin
        expAn[d] = 1'b0;
        expSeg   = hexSeg[shData[d*4 +: 4]];
        expDpo   = ~shDp[d];
      end
      @(negedge clk);
      checkOutput($sformatf("%s_k%0d", tag, k), expAn, expSeg, expDpo, (k == 16));
      if (k == midK) dataIn = midData;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
    dataIn = d;
    enIn   = e;
    dpIn   = p;
  endtask

  initial begin
    logic [15:0] prevData;
    logic [3:0]  prevLz;

    rst_n = 1'b0;
    applyStimulus(16'h1234, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'b1111, 7'h7F, 1'b1, 1'b0);

    rst_n = 1'b1;
    checkFrame("blank1", 16'h0000, 4'h0, 4'h0, 4'h0, 0, 16'h0000);
    checkFrame("f1234", 16'h1234, 4'hF, 4'h0, 4'h0, 5, 16'hFFFF);

    prevData = 16'hFFFF;
    prevLz   = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      dataIn = 16'h0000 | 16'(v);
      checkFrame($sformatf("sweep%0d", v), prevData, 4'hF, 4'h0, prevLz, 0, 16'h0000);
      prevData = 16'h0000 | 16'(v);
      prevLz   = LZ_SWEEP;
    end

    applyStimulus(16'h1234, 4'b0101, 4'b0001);
    checkFrame("sweep16", prevData, 4'hF, 4'h0, prevLz, 0, 16'h0000);
    applyStimulus(16'h0070, 4'hF, 4'h0);
    checkFrame("en0101", 16'h1234, 4'b0101, 4'b0001, 4'h0, 0, 16'h0000);
    checkFrame("d0070", 16'h0070, 4'hF, 4'h0, LZ_0070, 0, 16'h0000);

    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsync", 4'b1111, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rstHeld", 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkFrame("blank2", 16'h0000, 4'h0, 4'h0, 4'h0, 0, 16'h0000);
    checkFrame("d0070b", 16'h0070, 4'hF, 4'h0, LZ_0070, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
Name: ssd_scan

Overview:
- Downstream consumer of the 4-bit down/hex counter outputs.
- Takes four hex nibbles (counter value plus neighbouring digits), decodes them to seven-segment patterns and time-multiplexes them onto a 4-digit common-anode display (active-low anodes and cathodes).
- Contains its own refresh prescaler, digit scanner and per-frame shadow latch, so digit values never tear mid-scan.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays selected. Legal range ≥1; 0 is illegal.
- CNT_W, 17: prescaler width. Must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- ssd_scan_clk  in  1  system clock
- ssd_scan_rst_n  in  1  asynchronous, active-low reset
- ssd_scan_data  in  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- ssd_scan_digit_en  in  4  per-digit enable, active-high; 0 blanks that digit
- ssd_scan_dp  in  4  per-digit decimal point, active-high
- ssd_scan_an  out  4  anode select, active-low, one-hot-low or all-high
- ssd_scan_seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- ssd_scan_dpo  out  1  decimal-point cathode, active-low
- ssd_scan_frame  out  1  one-cycle pulse after each shadow load

Behaviour:
- Reset is asynchronous and active-low; one clock.
- Reset values:
  - prescaler cnt = 0; digit select sel = 0
  - shadow data = 0, shadow enable = 0, shadow dp = 0
  - ssd_scan_an = 4'b1111, ssd_scan_seg = 7'b1111111, ssd_scan_dpo = 1, ssd_scan_frame = 0
- Prescaler:
  - cnt increments every clock, 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1). With REFRESH_DIV = 1, tick is asserted every cycle.
- Scanner: on tick, sel advances 0→1→2→3→0. A full frame = 4×REFRESH_DIV cycles.
- Shadow load:
  - Occurs on the edge where tick && sel == 3, i.e. the same edge sel wraps to 0.
  - Captures ssd_scan_data, ssd_scan_digit_en and ssd_scan_dp.
  - Input changes at any other time have no visible effect until the next frame boundary.
- Output stage is registered:
  - an, seg and dpo at cycle t+1 are a function of sel(t) and shadow(t). Latency is 1 clock from a sel change.
  - an[sel] = 0 and all other an bits = 1.
  - If shadow enable[sel] = 0: an = 4'b1111, seg = 7'h7F, dpo = 1. The anode is also off.
  - Otherwise seg = hex decode of shadow nibble[sel] and dpo = ~shadow_dp[sel].
- Hex decode (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- ssd_scan_frame: high for exactly the one cycle following the shadow-load edge.
- First frame after reset is fully blank, because shadow enable = 0.
- Reset asserted mid-frame: all state returns immediately (asynchronously) to reset values. Scanning resumes from sel = 0, cnt = 0 on the first edge after release.

Optional Feature:
- Macro: SSD_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is additionally blanked when its nibble is 0 and every higher enabled digit in the shadow is also 0 or disabled.
  - Digit 0 is never blanked by this rule.
  - Evaluated on the shadow data, so the result is stable per frame.
- Undefined: zeros display as "0". No extra logic is instantiated.

Test Plan:
- REFRESH_DIV=4, data=16'h1234, digit_en=4'hF, dp=0, release reset and run 2 frames:
  - Frame 1: an = 1111 for all 16 cycles.
  - Frame 2: an sequence 1110/1101/1011/0111, each held 4 cycles; seg = 19, 30, 24, 79; frame pulses once per 16 cycles.
- All 16 nibbles cycled through digit 0 → each seg value matches the decode list exactly.
- Change data 16'h1234→16'hFFFF while sel = 1 → remaining digits of that frame still show 3, 2, 1; next frame shows 0E on all digits.
- digit_en=4'b0101, dp=4'b0001 → an never drives digit 1 or 3 low; dpo = 0 only while an = 1110.
- Assert rst_n low mid-frame for 1 cycle → outputs return to 1111/7F/1 asynchronously; the next frame after release is blank.
- Macro defined, data=16'h0070, digit_en=4'hF → digits 3 and 2 blank; digits 1 and 0 show 78 and 40. data=16'h0000 → only digit 0 shows 40.
